pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, control-bit layout and per-boundary kill masks for the
// pipelined datapath stage registers.
package pipe_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int CTRL_W_DEF = 10;
  localparam int CNT_W_DEF  = 16;

  // Control vector bit positions
  localparam int CB_REGWR    = 0;
  localparam int CB_ALUSRC   = 1;
  localparam int CB_REGDST   = 2;
  localparam int CB_MEMTOREG = 3;
  localparam int CB_MEMWR    = 4;
  localparam int CB_BRANCH   = 5;
  localparam int CB_JUMP     = 6;
  localparam int CB_EXTOP    = 7;
  localparam int CB_RTYPE    = 8;
  localparam int CB_ALUOP    = 9;

  localparam logic [CTRL_W_DEF-1:0] ID_EX_KILL =
    (CTRL_W_DEF'(1) << CB_REGWR)  | (CTRL_W_DEF'(1) << CB_MEMTOREG) |
    (CTRL_W_DEF'(1) << CB_MEMWR)  | (CTRL_W_DEF'(1) << CB_BRANCH)   |
    (CTRL_W_DEF'(1) << CB_JUMP);

  localparam logic [CTRL_W_DEF-1:0] EX_MEM_KILL =
    (CTRL_W_DEF'(1) << CB_REGWR) | (CTRL_W_DEF'(1) << CB_MEMTOREG) |
    (CTRL_W_DEF'(1) << CB_MEMWR);

  localparam logic [CTRL_W_DEF-1:0] MEM_WB_KILL =
    (CTRL_W_DEF'(1) << CB_REGWR) | (CTRL_W_DEF'(1) << CB_MEMTOREG);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, updated on the falling edge.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(negedge clk) cnt_q <= cnt_d;

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: main slot M plus skid slot S, NOP insertion on
// bubble and control kill on flush. Outputs come straight from M.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CTRL_W    = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(ID_EX_KILL),
  parameter int                CNT_W     = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_nop,
  output logic [CNT_W-1:0]  nop_cnt
);

  logic              m_v_q, m_v_d, m_nop_q, m_nop_d;
  logic              s_v_q, s_v_d, s_nop_q, s_nop_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;

  logic              push, pop, ins, w, w_nop;
  logic [CTRL_W-1:0] w_ctrl, s_ctrl_held;
  logic              s_nop_held;

  // in_ready only looks at registered S_v and bubble, never out_ready
  assign in_ready = !s_v_q && !bubble;
  assign push     = in_valid && in_ready;
  assign pop      = m_v_q && out_ready;
  assign ins      = bubble && !s_v_q;
  assign w        = push || ins;
  assign w_nop    = ins || flush;
  assign w_ctrl   = w_nop ? (in_ctrl & ~KILL_MASK) : in_ctrl;

  assign s_ctrl_held = flush ? (s_ctrl_q & ~KILL_MASK) : s_ctrl_q;
  assign s_nop_held  = flush | s_nop_q;

  always_comb begin
    m_v_d    = m_v_q;
    m_nop_d  = m_nop_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_v_d    = s_v_q;
    s_nop_d  = s_nop_held;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_held;
    // held, un-popped M entry is killed in place
    if (flush && m_v_q && !pop) begin
      m_ctrl_d = m_ctrl_q & ~KILL_MASK;
      m_nop_d  = 1'b1;
    end
    if (!m_v_q || (!s_v_q && pop)) begin
      if (w) begin
        m_v_d    = 1'b1;
        m_nop_d  = w_nop;
        m_data_d = in_data;
        m_ctrl_d = w_ctrl;
      end else if (m_v_q) begin
        m_v_d = 1'b0;
      end
    end else if (!s_v_q) begin
      if (w) begin
        s_v_d    = 1'b1;
        s_nop_d  = w_nop;
        s_data_d = in_data;
        s_ctrl_d = w_ctrl;
      end
    end else if (pop) begin
      m_v_d    = 1'b1;
      m_nop_d  = s_nop_held;
      m_data_d = s_data_q;
      m_ctrl_d = s_ctrl_held;
      s_v_d    = 1'b0;
      s_nop_d  = 1'b0;
      s_data_d = '0;
      s_ctrl_d = '0;
    end
  end

  always_ff @(negedge Clk) begin
    if (!Clrn) begin
      m_v_q    <= 1'b0;
      m_nop_q  <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_v_q    <= 1'b0;
      s_nop_q  <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_nop_q  <= m_nop_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_v_q    <= s_v_d;
      s_nop_q  <= s_nop_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_nop_cnt (
    .clk   (Clk),
    .clear (!Clrn),
    .inc   (w && w_nop),
    .cnt   (nop_cnt)
  );

  assign out_valid = m_v_q;
  assign out_nop   = m_nop_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected entries into a
// queue, a posedge monitor pops and compares every accepted output entry.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 16;
  localparam int CW = 10;
  localparam int NW = 2;
  localparam logic [CW-1:0] KM = 10'h079;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          nop;
  } ent_t;

  logic          clk = 1'b0;
  logic          Clrn, in_valid, in_ready, bubble, flush;
  logic          out_valid, out_ready, out_nop;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] nop_cnt;

  int checks = 0;
  int errors = 0;
  ent_t exp_q[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(ID_EX_KILL), .CNT_W(NW)) dut (
    .Clk(clk), .Clrn(Clrn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .bubble(bubble), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_nop(out_nop), .nop_cnt(nop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic n);
    exp_q.push_back('{data: d, ctrl: c, nop: n});
  endtask

  // one active (falling) edge, then settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Monitor: half a cycle before the active edge, an accepted M entry must match
  always @(posedge clk) begin
    if (Clrn && out_valid && out_ready) begin
      ent_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got data %0h ctrl %0h nop %0b, none expected",
                 out_data, out_ctrl, out_nop);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_ctrl !== e.ctrl || out_nop !== e.nop) begin
          errors++;
          $display("FAIL scoreboard_entry: got data %0h ctrl %0h nop %0b, expected data %0h ctrl %0h nop %0b",
                   out_data, out_ctrl, out_nop, e.data, e.ctrl, e.nop);
        end
      end
    end
  end

  initial begin
    Clrn = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    tick(); tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_nop_cnt",   32'(nop_cnt),   32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_out_ctrl",  32'(out_ctrl),  32'd0);

    // Stream 1..4 at full rate
    Clrn = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = 10'h002;
      expect_out(DW'(i), 10'h002, 1'b0);
      tick();
      chk("stream_out_data", 32'(out_data), 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure into the skid slot
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00AA; in_ctrl = 10'h005; tick();
    in_data = 16'h00BB; in_ctrl = 10'h0A2; tick();
    in_valid = 1'b0;
    chk("bp_in_ready_two", 32'(in_ready), 32'd0);
    chk("bp_out_data_a",   32'(out_data), 32'h00AA);
    expect_out(16'h00AA, 10'h005, 1'b0);
    expect_out(16'h00BB, 10'h0A2, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_out_data_b",   32'(out_data), 32'h00BB);
    chk("bp_in_ready_one", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Bubble: NOP inserted, upstream entry held then passed unmasked
    in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 10'h3FF; bubble = 1'b1;
    #1;
    chk("bubble_in_ready", 32'(in_ready), 32'd0);
    expect_out(16'h0055, 10'h386, 1'b1);
    tick();
    chk("bubble_out_ctrl", 32'(out_ctrl), 32'h386);
    chk("bubble_out_nop",  32'(out_nop),  32'd1);
    bubble = 1'b0;
    expect_out(16'h0055, 10'h3FF, 1'b0);
    tick();
    chk("bubble_next_ctrl", 32'(out_ctrl), 32'h3FF);
    in_valid = 1'b0;
    tick();
    chk("bubble_nop_cnt", 32'(nop_cnt), 32'd1);

    // Flush with two held entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; in_ctrl = 10'h3FF; tick();
    in_data = 16'h0022; in_ctrl = 10'h3F0; tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd1);
    chk("flush_out_ctrl",  32'(out_ctrl),  32'h386);
    chk("flush_out_nop",   32'(out_nop),   32'd1);
    chk("flush_out_data",  32'(out_data),  32'h0011);
    chk("flush_nop_cnt",   32'(nop_cnt),   32'd1);
    expect_out(16'h0011, 10'h386, 1'b1);
    expect_out(16'h0022, 10'h380, 1'b1);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("flush_drained", 32'(out_valid), 32'd0);

    // Reset while TWO entries are held
    in_valid = 1'b1; in_data = 16'h0033; in_ctrl = 10'h001; tick();
    in_data = 16'h0044; tick();
    in_valid = 1'b0;
    chk("rst_mid_two", 32'(in_ready), 32'd0);
    Clrn = 1'b0;
    tick();
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_out_ctrl",  32'(out_ctrl),  32'd0);
    chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mid_nop_cnt",   32'(nop_cnt),   32'd0);
    Clrn = 1'b1;

    // Counter saturation: 5 bubbles on a 2-bit counter
    out_ready = 1'b1; in_data = 16'h0077; in_ctrl = 10'h3FF; bubble = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out(16'h0077, 10'h386, 1'b1);
      tick();
    end
    bubble = 1'b0;
    tick();
    chk("sat_nop_cnt",   32'(nop_cnt),      32'd3);
    chk("sat_drained",   32'(out_valid),    32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
